// File: rtl/dec_pkg.sv
// ---------------------------------------------------------------------------
// dec_pkg
// Shared definitions for the pipelined 3-to-8 decoder slice.
//   CODE_W       width of the binary code (3)
//   ONEHOT_W     width of the decoded one-hot word (8)
//   ONEHOT_IDLE  value presented on out_onehot when nothing is buffered
//   occ_t        occupancy of the 2-entry output buffer (EMPTY/ONE/FULL)
//   entry_t      one buffered entry: decoded word plus the code that made it
// ---------------------------------------------------------------------------
package dec_pkg;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 8;

  localparam logic [ONEHOT_W-1:0] ONEHOT_IDLE = 8'h00;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  typedef struct packed {
    logic [ONEHOT_W-1:0] onehot;
    logic [CODE_W-1:0]   code;
  } entry_t;

  // An unused buffer slot holds this value so the outputs read as idle, not X.
  localparam entry_t ENTRY_IDLE = '{onehot: ONEHOT_IDLE, code: {CODE_W{1'b0}}};

endpackage

// File: rtl/decoder_3to8_pipe_if.sv
// ---------------------------------------------------------------------------
// decoder_3to8_pipe_if
// Handshake bundle for decoder_3to8_pipe.
//   in_valid / in_ready / in_code / in_en       upstream code transfer
//   out_valid / out_ready / out_onehot / out_code downstream one-hot transfer
//   out_cnt                                      completed output transfers
// Modports:
//   master  the environment side (drives codes, accepts one-hot words)
//   slave   the decoder side
// ---------------------------------------------------------------------------
interface decoder_3to8_pipe_if
  import dec_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic                in_valid;
  logic                in_ready;
  logic [CODE_W-1:0]   in_code;
  logic                in_en;

  logic                out_valid;
  logic                out_ready;
  logic [ONEHOT_W-1:0] out_onehot;
  logic [CODE_W-1:0]   out_code;
  logic [CNT_W-1:0]    out_cnt;

  modport master (
    output in_valid, in_code, in_en, out_ready,
    input  in_ready, out_valid, out_onehot, out_code, out_cnt
  );

  modport slave (
    input  in_valid, in_code, in_en, out_ready,
    output in_ready, out_valid, out_onehot, out_code, out_cnt
  );

endinterface

// File: rtl/decoder_3to8_pipe_comb.sv
// ---------------------------------------------------------------------------
// decoder_3to8_comb
// Purely combinational 3-to-8 binary-to-one-hot decoder.
//   code    in   3   binary code 0..7
//   en      in   1   enable; 0 forces the all-zero word
//   onehot  out  8   bit[code] set when en=1, else ONEHOT_IDLE
// ---------------------------------------------------------------------------
module decoder_3to8_comb
  import dec_pkg::*;
(
  input  logic [CODE_W-1:0]   code,
  input  logic                en,
  output logic [ONEHOT_W-1:0] onehot
);

  assign onehot = en ? (ONEHOT_W'(1) << code) : ONEHOT_IDLE;

endmodule

// File: rtl/decoder_3to8_pipe.sv
// ---------------------------------------------------------------------------
// decoder_3to8_pipe
// Registered 3-to-8 decoder with valid/ready on both sides and a 2-entry
// output buffer. Codes are decoded on the way in, so the buffer stores the
// finished {onehot, code} pair and every output is driven straight from a
// register.
//   clk   in   1    single clock, rising edge
//   rst   in   1    asynchronous, active-high reset
//   bus   slave modport of decoder_3to8_pipe_if:
//           in_valid/in_ready/in_code/in_en      upstream handshake
//           out_valid/out_ready/out_onehot/out_code downstream handshake
//           out_cnt  completed output transfers modulo 2^CNT_W
// ---------------------------------------------------------------------------
module decoder_3to8_pipe
  import dec_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  decoder_3to8_pipe_if.slave  bus
);

  occ_t             state_q;
  occ_t             state_d;
  entry_t           head_q;
  entry_t           head_d;
  entry_t           tail_q;
  entry_t           tail_d;
  logic             ready_q;
  logic [CNT_W-1:0] cnt_q;

  logic [ONEHOT_W-1:0] dec_onehot;
  entry_t              in_entry;
  logic                push;
  logic                pop;

  decoder_3to8_comb u_dec (
    .code   (bus.in_code),
    .en     (bus.in_en),
    .onehot (dec_onehot)
  );

  assign in_entry = '{onehot: dec_onehot, code: bus.in_code};

  // ready_q already encodes "not full", so push never needs the state here.
  assign push = bus.in_valid & ready_q;
  assign pop  = (state_q != EMPTY) & bus.out_ready;

  // Next-state and buffer-content selection. The head slot always feeds the
  // outputs; the tail slot is only used while two entries are held. A slot
  // that goes out of use is returned to ENTRY_IDLE so an empty buffer shows
  // 8'h00 / 3'b000 without any output gating.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = in_entry;
        end
      end
      ONE: begin
        case ({push, pop})
          2'b11: begin
            head_d = in_entry;
          end
          2'b10: begin
            state_d = FULL;
            tail_d  = in_entry;
          end
          2'b01: begin
            state_d = EMPTY;
            head_d  = ENTRY_IDLE;
          end
          default: begin
          end
        endcase
      end
      FULL: begin
        if (pop) begin
          state_d = ONE;
          head_d  = tail_q;
          tail_d  = ENTRY_IDLE;
        end
      end
      default: begin
        state_d = EMPTY;
        head_d  = ENTRY_IDLE;
        tail_d  = ENTRY_IDLE;
      end
    endcase
  end

  // State register. ready_q is precomputed from the next occupancy so that
  // in_ready is a plain flop: nothing on the input or output handshake can
  // reach it combinationally. It resets to 0 and rises on the first edge
  // after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= ENTRY_IDLE;
      tail_q  <= ENTRY_IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ready_q <= (state_d != FULL);
    end
  end

  // Completed-transfer counter, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (pop) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.out_valid  = (state_q != EMPTY);
  assign bus.out_onehot = head_q.onehot;
  assign bus.out_code   = head_q.code;
  assign bus.out_cnt    = cnt_q;

endmodule

// File: tb/tb_decoder_3to8_pipe.sv
// ---------------------------------------------------------------------------
// tb_decoder_3to8_pipe
// Self-checking bench for decoder_3to8_pipe (CNT_W=4 so the counter wraps).
// A queue-based model predicts buffer contents, ready, valid and count; a
// negedge compare process checks the DUT against it every cycle, and directed
// literal checks pin the model at the interesting points.
// ---------------------------------------------------------------------------
module tb_decoder_3to8_pipe;

  localparam int TB_CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_cmp  = 0;
  int n_fail = 0;

  decoder_3to8_pipe_if #(.CNT_W(TB_CNT_W)) bus ();

  decoder_3to8_pipe #(.CNT_W(TB_CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: a plain FIFO of accepted {code, en}, capped at two entries.
  typedef struct {
    int code;
    bit en;
  } mentry_t;

  mentry_t q[$];
  int      pops     = 0;
  bit      ready_ok = 1'b0;

  logic [7:0] sweep_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                8'h10, 8'h20, 8'h40, 8'h80};

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_onehot(input mentry_t e);
    return e.en ? (2 ** e.code) : 0;
  endfunction

  // 8-to-3 encoder used for the round-trip check; -1 for a non-one-hot word.
  function automatic int encode8(input logic [7:0] w);
    int idx = -1;
    int ones = 0;
    for (int i = 0; i < 8; i++) begin
      if (w[i]) begin
        idx = i;
        ones++;
      end
    end
    return (ones == 1) ? idx : -1;
  endfunction

  // Model update on each edge: pop first, then push, so the
  // push-and-pop-at-one case leaves the new entry as head.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      pops     = 0;
      ready_ok = 1'b0;
    end else begin
      bit do_push;
      bit do_pop;
      do_push = bus.in_valid && ready_ok && (q.size() < 2);
      do_pop  = (q.size() > 0) && bus.out_ready;
      if (do_pop) begin
        void'(q.pop_front());
        pops++;
      end
      if (do_push) begin
        q.push_back('{code: int'(bus.in_code), en: bus.in_en});
      end
      ready_ok = 1'b1;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      bit exp_v;
      int exp_oh;
      int exp_code;
      exp_v    = (q.size() > 0);
      exp_oh   = exp_v ? model_onehot(q[0]) : 0;
      exp_code = exp_v ? q[0].code : 0;
      check_output("m_out_valid", 32'(bus.out_valid), 32'(exp_v));
      check_output("m_in_ready", 32'(bus.in_ready), 32'(ready_ok && (q.size() < 2)));
      check_output("m_out_onehot", 32'(bus.out_onehot), exp_oh);
      check_output("m_out_code", 32'(bus.out_code), exp_code);
      check_output("m_out_cnt", 32'(bus.out_cnt), pops % (2 ** TB_CNT_W));
      if (bus.out_valid && (bus.out_onehot != 8'h00)) begin
        check_output("roundtrip", encode8(bus.out_onehot), 32'(bus.out_code));
      end
    end
  end

  // Called at a negedge: drive inputs, then advance to the next negedge.
  task automatic apply_stimulus(input bit v, input int code, input bit en, input bit rdy);
    bus.in_valid  = v;
    bus.in_code   = 3'(code);
    bus.in_en     = en;
    bus.out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic idle_cycle(input bit rdy);
    apply_stimulus(1'b0, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), rdy);
  endtask

  // Assert reset off-edge, check the asynchronous clear, then release.
  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1;
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_out_onehot", 32'(bus.out_onehot), 32'h00);
    check_output("rst_out_code", 32'(bus.out_code), 32'd0);
    check_output("rst_out_cnt", 32'(bus.out_cnt), 32'd0);
    check_output("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    idle_cycle(1'b0);
    check_output("ready_after_release", 32'(bus.in_ready), 32'd1);
    check_output("empty_after_release", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_code   = 3'd0;
    bus.in_en     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset held from time zero.
    #1;
    check_output("init_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("init_out_onehot", 32'(bus.out_onehot), 32'h00);
    check_output("init_out_code", 32'(bus.out_code), 32'd0);
    check_output("init_out_cnt", 32'(bus.out_cnt), 32'd0);
    check_output("init_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    idle_cycle(1'b0);
    check_output("first_ready", 32'(bus.in_ready), 32'd1);

    // Fill to two entries with one transfer completed, then reset mid-stream.
    apply_stimulus(1'b1, 3, 1'b1, 1'b1);
    apply_stimulus(1'b1, 6, 1'b1, 1'b1);
    apply_stimulus(1'b1, 1, 1'b1, 1'b0);
    check_output("full_in_ready", 32'(bus.in_ready), 32'd0);
    check_output("full_head", 32'(bus.out_onehot), 32'h40);
    check_output("full_cnt", 32'(bus.out_cnt), 32'd1);
    pulse_reset();

    // Sweep all codes back-to-back with the consumer always ready.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1, i, 1'b1, 1'b1);
      check_output("sweep_onehot", 32'(bus.out_onehot), 32'(sweep_exp[i]));
      check_output("sweep_code", 32'(bus.out_code), i);
    end
    idle_cycle(1'b1);
    check_output("sweep_drained", 32'(bus.out_valid), 32'd0);
    check_output("sweep_cnt", 32'(bus.out_cnt), 32'd8);

    // Enable low: all-zero word but the code still travels with it.
    apply_stimulus(1'b1, 5, 1'b0, 1'b0);
    check_output("en0_valid", 32'(bus.out_valid), 32'd1);
    check_output("en0_onehot", 32'(bus.out_onehot), 32'h00);
    check_output("en0_code", 32'(bus.out_code), 32'd5);
    idle_cycle(1'b1);

    // Backpressure: only two of three codes fit; head holds.
    apply_stimulus(1'b1, 6, 1'b1, 1'b0);
    apply_stimulus(1'b1, 2, 1'b1, 1'b0);
    check_output("bp_in_ready", 32'(bus.in_ready), 32'd0);
    check_output("bp_head", 32'(bus.out_onehot), 32'h40);
    apply_stimulus(1'b1, 7, 1'b1, 1'b0);
    check_output("bp_hold", 32'(bus.out_onehot), 32'h40);
    check_output("bp_still_full", 32'(bus.in_ready), 32'd0);
    apply_stimulus(1'b1, 7, 1'b1, 1'b1);
    check_output("bp_second", 32'(bus.out_onehot), 32'h04);
    apply_stimulus(1'b1, 7, 1'b1, 1'b1);
    check_output("bp_third", 32'(bus.out_onehot), 32'h80);
    idle_cycle(1'b1);
    check_output("bp_drained", 32'(bus.out_valid), 32'd0);

    // Push and pop in the same cycle at occupancy one.
    apply_stimulus(1'b1, 1, 1'b1, 1'b0);
    check_output("sim_head0", 32'(bus.out_onehot), 32'h02);
    apply_stimulus(1'b1, 4, 1'b1, 1'b1);
    check_output("sim_head1", 32'(bus.out_onehot), 32'h10);
    check_output("sim_valid", 32'(bus.out_valid), 32'd1);
    check_output("sim_ready", 32'(bus.in_ready), 32'd1);
    idle_cycle(1'b1);
    check_output("sim_drained", 32'(bus.out_valid), 32'd0);

    // Random round-trip run: 20 transfers from a cleared counter wraps to 4.
    pulse_reset();
    begin
      int  pushed  = 0;
      int  cyc     = 0;
      bit  pending = 1'b0;
      bit  v       = 1'b0;
      int  c       = 0;
      bit  r;
      bit  acc;
      while ((pops < 20) && (cyc < 400)) begin
        if (!pending) begin
          v = (pushed < 20) && ($urandom_range(0, 3) != 0);
          c = int'($urandom_range(0, 7));
        end
        r   = 1'($urandom_range(0, 1));
        acc = v && ready_ok && (q.size() < 2);
        if (acc) pushed++;
        pending = v && !acc;
        apply_stimulus(v, c, 1'b1, r);
        cyc++;
      end
      check_output("rt_transfers", pops, 32'd20);
    end
    idle_cycle(1'b0);
    check_output("rt_cnt_wrap", 32'(bus.out_cnt), 32'd4);
    check_output("rt_empty", 32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
